// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle controller and its datapath.
// The controller drives the strobes. The datapath returns the IR fields and the ALU zero flag.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero,
        output alu_op, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_source,
               i_or_d, mem_read, mem_write, ir_write, reg_dst, reg_write,
               mem_to_reg, state
    );

    modport slave (
        output opcode, funct, zero,
        input  alu_op, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_source,
               i_or_d, mem_read, mem_write, ir_write, reg_dst, reg_write,
               mem_to_reg, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore-style control FSM for a MIPS-subset multicycle datapath.
// Supported instructions are lw, sw, R-type, beq, j and addi.
module multicycle_control (
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_control_if.master        bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEM_ADR = 4'd2,
        MEM_RD  = 4'd3,
        MEM_WB  = 4'd4,
        MEM_WR  = 4'd5,
        EXEC_R  = 4'd6,
        R_WB    = 4'd7,
        BEQ     = 4'd8,
        JUMP    = 4'd9,
        ADDI_EX = 4'd10,
        ADDI_WB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_t     state_q;
    state_t     state_d;

    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = FETCH;
        alu_op        = 4'b0000;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALU_ADD;
                pc_write  = 1'b1;
                state_d   = DECODE;
            end
            DECODE: begin
                // The branch target is computed speculatively while the opcode is examined.
                alu_src_b = 2'b11;
                alu_op    = ALU_ADD;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEM_ADR;
                    OP_RTYPE:     state_d = EXEC_R;
                    OP_BEQ:       state_d = BEQ;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDI_EX;
                    default:      state_d = FETCH;
                endcase
            end
            MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALU_ADD;
                state_d   = (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                state_d  = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                state_d   = FETCH;
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                case (bus.funct)
                    6'b100010: alu_op = ALU_SUB;
                    6'b100100: alu_op = ALU_AND;
                    6'b100101: alu_op = ALU_OR;
                    6'b101010: alu_op = ALU_SLT;
                    default:   alu_op = ALU_ADD;
                endcase
                state_d = R_WB;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = FETCH;
            end
            BEQ: begin
                // The PC is written only when the datapath combines this enable with zero.
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                state_d       = FETCH;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = FETCH;
            end
            ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALU_ADD;
                state_d   = ADDI_WB;
            end
            ADDI_WB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign bus.alu_op        = alu_op;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.pc_write      = pc_write;
    assign bus.pc_write_cond = pc_write_cond;
    assign bus.pc_source     = pc_source;
    assign bus.i_or_d        = i_or_d;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.ir_write      = ir_write;
    assign bus.reg_dst       = reg_dst;
    assign bus.reg_write     = reg_write;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.state         = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed and randomized bench for multicycle_control.
// Each instruction is predicted as a list of states, and each state is mapped to its control word.
module tb_multicycle_control;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cycles;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed control word: alu_op, src_a, src_b, pc_write, pc_write_cond, pc_source,
    // i_or_d, mem_read, mem_write, ir_write, reg_dst, reg_write, mem_to_reg
    logic [17:0] ctrl_obs;
    assign ctrl_obs = {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.pc_write,
                       bus.pc_write_cond, bus.pc_source, bus.i_or_d, bus.mem_read,
                       bus.mem_write, bus.ir_write, bus.reg_dst, bus.reg_write,
                       bus.mem_to_reg};

    function automatic logic [17:0] pack(input logic [3:0] op, input logic a, input logic [1:0] b,
                                         input logic pw, input logic pwc, input logic [1:0] ps,
                                         input logic iod, input logic mr, input logic mw,
                                         input logic irw, input logic rd, input logic rw,
                                         input logic m2r);
        return {op, a, b, pw, pwc, ps, iod, mr, mw, irw, rd, rw, m2r};
    endfunction

    function automatic logic [3:0] r_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b0010;
        endcase
    endfunction

    // Expected control word for each numbered state, taken from the state table.
    function automatic logic [17:0] exp_ctrl(input int st, input logic [5:0] f);
        case (st)
            0:  return pack(4'b0010, 0, 2'b01, 1, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0);
            1:  return pack(4'b0010, 0, 2'b11, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
            2:  return pack(4'b0010, 1, 2'b10, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
            3:  return pack(4'b0000, 0, 2'b00, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0);
            4:  return pack(4'b0000, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1);
            5:  return pack(4'b0000, 0, 2'b00, 0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0);
            6:  return pack(r_alu(f), 1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
            7:  return pack(4'b0000, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0);
            8:  return pack(4'b0110, 1, 2'b00, 0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0);
            9:  return pack(4'b0000, 0, 2'b00, 1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0);
            10: return pack(4'b0010, 1, 2'b10, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
            11: return pack(4'b0000, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0);
            default: return 18'h0;
        endcase
    endfunction

    // State path taken by one instruction, starting in FETCH.
    task automatic build_seq(input logic [5:0] op, output int len, output int seq[6]);
        seq = '{0, 1, 0, 0, 0, 0};
        case (op)
            6'b100011: begin seq[2] = 2;  seq[3] = 3; seq[4] = 4; len = 5; end
            6'b101011: begin seq[2] = 2;  seq[3] = 5; len = 4; end
            6'b000000: begin seq[2] = 6;  seq[3] = 7; len = 4; end
            6'b001000: begin seq[2] = 10; seq[3] = 11; len = 4; end
            6'b000100: begin seq[2] = 8;  len = 3; end
            6'b000010: begin seq[2] = 9;  len = 3; end
            default:   len = 2;
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_invariants();
        check("mem_rd_wr_excl", {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
        check("pc_wr_excl", {31'd0, bus.pc_write & bus.pc_write_cond}, 32'd0);
        check("state_range", {31'd0, (bus.state > 4'd11)}, 32'd0);
    endtask

    // Runs one instruction from FETCH, checking state and controls in every cycle,
    // then confirms the return to FETCH after the predicted latency.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic z,
                             input bit verbose);
        int len;
        int seq[6];
        build_seq(op, len, seq);
        bus.opcode = op;
        bus.funct  = f;
        bus.zero   = z;
        for (int i = 0; i < len; i++) begin
            check("state", {28'd0, bus.state}, seq[i]);
            check("ctrl", {14'd0, ctrl_obs}, {14'd0, exp_ctrl(seq[i], f)});
            check_invariants();
            @(posedge clk);
            #1;
            cycles++;
        end
        check("latency_end", {28'd0, bus.state}, 32'd0);
        if (verbose)
            $display("instr op=%b funct=%b zero=%0d cycles=%0d", op, f, z, len);
    endtask

    initial begin
        int st;
        checks = 0;
        errors = 0;
        cycles = 0;
        rst_n      = 1'b0;
        bus.opcode = 6'b000000;
        bus.funct  = 6'b000000;
        bus.zero   = 1'b0;

        // Reset state, held across clock edges.
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {28'd0, bus.state}, 32'd0);
        check("reset_ctrl", {14'd0, ctrl_obs}, {14'd0, exp_ctrl(0, 6'd0)});
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset released");

        // lw path 0,1,2,3,4,0
        run_instr(6'b100011, 6'b000000, 1'b0, 1'b1);
        // sw, R-type sub / slt / and / or / add / unknown funct, addi, beq, j, unsupported
        run_instr(6'b101011, 6'b000000, 1'b0, 1'b1);
        run_instr(6'b000000, 6'b100010, 1'b0, 1'b1);
        run_instr(6'b000000, 6'b101010, 1'b0, 1'b1);
        run_instr(6'b000000, 6'b100100, 1'b0, 1'b1);
        run_instr(6'b000000, 6'b100101, 1'b0, 1'b1);
        run_instr(6'b000000, 6'b100000, 1'b0, 1'b1);
        run_instr(6'b000000, 6'b111111, 1'b0, 1'b1);
        run_instr(6'b001000, 6'b000000, 1'b0, 1'b1);
        run_instr(6'b000100, 6'b000000, 1'b0, 1'b1);
        run_instr(6'b000100, 6'b000000, 1'b1, 1'b1);
        run_instr(6'b000010, 6'b000000, 1'b0, 1'b1);
        run_instr(6'b111111, 6'b000000, 1'b0, 1'b1);

        // Asynchronous reset while in MEM_RD.
        bus.opcode = 6'b100011;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_mem_rd", {28'd0, bus.state}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_state", {28'd0, bus.state}, 32'd0);
        check("async_reset_mem_read", {31'd0, bus.mem_read}, 32'd1);
        check("async_reset_ir_write", {31'd0, bus.ir_write}, 32'd1);
        check("async_reset_pc_write", {31'd0, bus.pc_write}, 32'd1);
        @(posedge clk);
        #1;
        check("reset_hold", {28'd0, bus.state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("async reset in MEM_RD done");
        run_instr(6'b000000, 6'b100010, 1'b0, 1'b1);

        // Randomized instruction stream.
        while (cycles < 10000) begin
            logic [5:0] op;
            logic [5:0] f;
            int sel;
            sel = $urandom_range(0, 7);
            f   = 6'($urandom_range(0, 63));
            case (sel)
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: begin op = 6'b000000; if ($urandom_range(0, 1) == 1) f = {3'b100, 3'($urandom_range(0, 7))}; end
                3: op = 6'b000100;
                4: op = 6'b000010;
                5: op = 6'b001000;
                default: op = 6'($urandom_range(0, 63));
            endcase
            run_instr(op, f, 1'($urandom_range(0, 1)), 1'b0);
        end
        st = cycles;
        $display("random stream done: %0d cycles", st);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 opcode  input  6  instruction bits [31:26], driven from the IR.
REQ-005 funct  input  6  instruction bits [5:0], driven from the IR.
REQ-006 zero  input  1  ALU zero flag (out32 == 0).
REQ-007 alu_op  output  4  ALU operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
REQ-008 alu_src_a  output  1  ALU A select: 0 PC, 1 register A.
REQ-009 alu_src_b  output  2  ALU B select: 00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-010 pc_write, pc_write_cond  output  1 each  unconditional and zero-qualified PC write enables.
REQ-011 pc_source  output  2  PC next: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-012 i_or_d, mem_read, mem_write, ir_write  output  1 each  memory address select (0 PC, 1 ALUOut), read, write, and IR load strobes.
REQ-013 reg_dst, reg_write, mem_to_reg  output  1 each  write-register select (0 rt, 1 rd), register-file write, and write-data select (0 ALUOut, 1 MDR).
REQ-014 state  output  4  current state encoding, for debug.

Function
REQ-015 The block SHALL be a Moore FSM; all outputs SHALL decode from the state register and, in EXEC_R, from funct.
REQ-016 States and encoding: FETCH 0, DECODE 1, MEM_ADR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, R_WB 7, BEQ 8, JUMP 9, ADDI_EX 10, ADDI_WB 11.
REQ-017 FETCH: mem_read=1, ir_write=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=0010, pc_source=00, pc_write=1; next DECODE.
REQ-018 DECODE: alu_src_a=0, alu_src_b=11, alu_op=0010 (branch target precompute); next by opcode: 100011 or 101011 -> MEM_ADR; 000000 -> EXEC_R; 000100 -> BEQ; 000010 -> JUMP; 001000 -> ADDI_EX; any other -> FETCH (treated as NOP).
REQ-019 MEM_ADR: alu_src_a=1, alu_src_b=10, alu_op=0010; next MEM_RD for opcode 100011, else MEM_WR.
REQ-020 MEM_RD: mem_read=1, i_or_d=1; next MEM_WB.
REQ-021 MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; next FETCH.
REQ-022 MEM_WR: mem_write=1, i_or_d=1; next FETCH.
REQ-023 EXEC_R: alu_src_a=1, alu_src_b=00; alu_op by funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, any other -> 0010; next R_WB.
REQ-024 R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-025 BEQ: alu_src_a=1, alu_src_b=00, alu_op=0110, pc_write_cond=1, pc_source=01; next FETCH; the PC loads only when zero=1 on that edge.
REQ-026 JUMP: pc_write=1, pc_source=10; next FETCH.
REQ-027 ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=0010; next ADDI_WB.
REQ-028 ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0; next FETCH.
REQ-029 Every output not listed for a state SHALL be 0; an unused encoding (12-15) SHALL drive all strobes 0 and return to FETCH on the next edge.
REQ-030 Instruction latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unsupported opcode 2.
REQ-031 mem_read and mem_write SHALL never both be 1; pc_write and pc_write_cond SHALL never both be 1.

Reset
REQ-032 rst_n=0 SHALL force state FETCH immediately, independent of clk, including mid-instruction; state SHALL hold FETCH while rst_n=0.
REQ-033 After release, the first rising edge with rst_n=1 SHALL perform the FETCH transition to DECODE.

Verification
REQ-034 Reset asserted in MEM_RD, asynchronous to clk -> state=0 before the next edge; mem_read=1, ir_write=1, pc_write=1.
REQ-035 opcode=100011 from reset -> state sequence 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 only in state 4.
REQ-036 opcode=000000 with funct 100010, then with funct 101010 -> alu_op=0110, then 0111, in EXEC_R; reg_dst=1 in R_WB.
REQ-037 opcode=000100, zero=0 and then zero=1 -> state sequence 0,1,8,0; pc_write_cond=1 and pc_source=01 in state 8; pc_write=0.
REQ-038 opcode=111111 -> state sequence 0,1,0; no reg_write or mem_write pulse.
REQ-039 Random opcode and funct for 10k cycles -> no cycle with mem_read and mem_write both 1, or pc_write and pc_write_cond both 1; state always in 0-11.
